bus_transfer_sequencer: RTL and testbench

- Schedules register-to-register transfers over the shared CPU data bus.
- Accepts transfer commands {source code, destination code, hold count} through a valid/ready port and buffers them in a small FIFO.
- Issues commands one at a time by driving exactly one one-hot bus-source strobe for the transfer's duration, plus a destination load pulse on its final cycle.
- Sits between the control unit (or a debug/test master) and the bus source encoder. The strobe outputs connect directly to the encoder's source-select inputs.

---
 rtl/bus_pkg.sv | 24 ++
 rtl/cmd_fifo.sv | 43 ++++
 rtl/bus_transfer_sequencer.sv | 108 ++++++++++
 tb/tb_bus_transfer_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: source codes, FSM states and command format shared by the bus transfer sequencer
package bus_pkg;
  localparam logic [4:0] SRC_R0     = 5'd0;
  localparam logic [4:0] SRC_R15    = 5'd15;
  localparam logic [4:0] SRC_HI     = 5'd16;
  localparam logic [4:0] SRC_LO     = 5'd17;
  localparam logic [4:0] SRC_Y      = 5'd18;
  localparam logic [4:0] SRC_ZHIGH  = 5'd19;
  localparam logic [4:0] SRC_ZLOW   = 5'd20;
  localparam logic [4:0] SRC_PC     = 5'd21;
  localparam logic [4:0] SRC_MDR    = 5'd22;
  localparam logic [4:0] SRC_INPORT = 5'd23;
  localparam logic [4:0] SRC_C      = 5'd24;
  localparam logic [4:0] SRC_COUNT  = 5'd25;
  typedef enum logic {IDLE, DRIVE} state_t;
  typedef struct packed {
    logic [4:0] src;
    logic [4:0] dst;
    logic [1:0] hold;
  } cmd_t;
  function automatic logic cmd_ok(input cmd_t c);
    return (c.src < SRC_COUNT) && (c.dst < SRC_COUNT);
  endfunction
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO with combinational head read and exposed occupancy count
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end
  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/bus_transfer_sequencer.sv
// bus_transfer_sequencer: queues register transfers and drives one-hot bus source strobes
module bus_transfer_sequencer
  import bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic [4:0]  cmdSrc,
  input  logic [4:0]  cmdDst,
  input  logic [1:0]  cmdHold,
  output logic [15:0] RoutSignals,
  output logic        HIout,
  output logic        LOout,
  output logic        Yout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        PCout,
  output logic        MDRout,
  output logic        InPortout,
  output logic        Cout,
  output logic [4:0]  dstSelect,
  output logic        dstLoad,
  output logic        errInvalid,
  output logic        busy
);
  logic push, pop, full, empty;
  logic [$clog2(DEPTH):0] count;
  cmd_t head;
  state_t state_q, state_d;
  logic [1:0] hold_q, hold_d;
  logic [SRC_COUNT-1:0] strobe_q, strobe_d;
  logic [4:0] dst_q, dst_d;
  logic load_q, load_d, err_q, err_d, busy_q, busy_d;

  cmd_fifo #(.DEPTH(DEPTH), .W($bits(cmd_t))) u_fifo (
    .clk(clock), .rst_n(clear), .push(push), .pop(pop),
    .wdata({cmdSrc, cmdDst, cmdHold}), .rdata(head),
    .count(count), .full(full), .empty(empty)
  );

  assign push = cmdValid && !full;
  assign pop = !empty && (state_q == IDLE || hold_q == '0);
  assign cmdReady = !full;

  // Invalid or absent commands fall through to IDLE; an invalid pop flags errInvalid next cycle
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    strobe_d = strobe_q;
    dst_d = dst_q;
    err_d = 1'b0;
    if (state_q == DRIVE && hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end else if (pop && cmd_ok(head)) begin
      state_d = DRIVE;
      hold_d = head.hold;
      strobe_d = '0;
      strobe_d[head.src] = 1'b1;
      dst_d = head.dst;
    end else begin
      state_d = IDLE;
      hold_d = '0;
      strobe_d = '0;
      dst_d = '0;
      err_d = pop;
    end
    load_d = state_d == DRIVE && hold_d == '0;
    busy_d = state_d == DRIVE || push || count != {{$clog2(DEPTH){1'b0}}, pop};
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      hold_q <= '0;
      strobe_q <= '0;
      dst_q <= '0;
      load_q <= 1'b0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      strobe_q <= strobe_d;
      dst_q <= dst_d;
      load_q <= load_d;
      err_q <= err_d;
      busy_q <= busy_d;
    end
  end

  assign RoutSignals = strobe_q[SRC_R15:SRC_R0];
  assign HIout      = strobe_q[SRC_HI];
  assign LOout      = strobe_q[SRC_LO];
  assign Yout       = strobe_q[SRC_Y];
  assign Zhighout   = strobe_q[SRC_ZHIGH];
  assign Zlowout    = strobe_q[SRC_ZLOW];
  assign PCout      = strobe_q[SRC_PC];
  assign MDRout     = strobe_q[SRC_MDR];
  assign InPortout  = strobe_q[SRC_INPORT];
  assign Cout       = strobe_q[SRC_C];
  assign dstSelect  = dst_q;
  assign dstLoad    = load_q;
  assign errInvalid = err_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// tb_bus_transfer_sequencer: schedule-based model of the sequencer checked every cycle plus directed literal checks
module tb_bus_transfer_sequencer;
  localparam int DEPTH = 4;
  localparam int MAXC = 2048;
  logic clock = 1'b0, clear = 1'b0, cmdValid = 1'b0;
  logic [4:0] cmdSrc = '0, cmdDst = '0;
  logic [1:0] cmdHold = '0;
  logic cmdReady, HIout, LOout, Yout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout;
  logic dstLoad, errInvalid, busy;
  logic [15:0] RoutSignals;
  logic [4:0] dstSelect;
  logic [24:0] dut_vec;
  int vecs = 0, fails = 0, cyc = 0, mcount = 0, next_free = 0;
  int exp_src[MAXC], exp_dst[MAXC], npop[MAXC];
  bit exp_load[MAXC], exp_err[MAXC];

  bus_transfer_sequencer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .clear(clear), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdSrc(cmdSrc), .cmdDst(cmdDst), .cmdHold(cmdHold), .RoutSignals(RoutSignals),
    .HIout(HIout), .LOout(LOout), .Yout(Yout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout), .InPortout(InPortout), .Cout(Cout),
    .dstSelect(dstSelect), .dstLoad(dstLoad), .errInvalid(errInvalid), .busy(busy)
  );

  always #5 clock = ~clock;
  assign dut_vec = {Cout, InPortout, MDRout, PCout, Zlowout, Zhighout, Yout, LOout, HIout, RoutSignals};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < MAXC; i++) begin
      exp_src[i] = -1;
      exp_dst[i] = 0;
      exp_load[i] = 1'b0;
      exp_err[i] = 1'b0;
      npop[i] = 0;
    end
    mcount = 0;
    next_free = 0;
  endtask

  // Each accepted command claims the first slot after both its arrival and the previous transfer
  always @(posedge clock) begin
    bit acc;
    int p;
    cyc++;
    if (!clear) model_reset();
    else begin
      acc = cmdValid && (mcount < DEPTH);
      mcount = mcount + int'(acc) - npop[cyc];
      if (acc) begin
        p = (cyc + 1 > next_free) ? cyc + 1 : next_free;
        npop[p]++;
        if (cmdSrc < 5'd25 && cmdDst < 5'd25) begin
          for (int k = 0; k <= int'(cmdHold); k++) begin
            exp_src[p+k] = int'(cmdSrc);
            exp_dst[p+k] = int'(cmdDst);
          end
          exp_load[p+int'(cmdHold)] = 1'b1;
          next_free = p + int'(cmdHold) + 1;
        end else begin
          exp_err[p] = 1'b1;
          next_free = p + 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    logic [24:0] ev;
    if (clear && cyc > 0) begin
      ev = '0;
      if (exp_src[cyc] >= 0) ev[exp_src[cyc]] = 1'b1;
      check("strobes", 32'(dut_vec), 32'(ev));
      check("one_hot", 32'($countones(dut_vec) <= 1), 32'd1);
      check("dstSelect", 32'(dstSelect), 32'(exp_dst[cyc]));
      check("dstLoad", 32'(dstLoad), 32'(exp_load[cyc]));
      check("errInvalid", 32'(errInvalid), 32'(exp_err[cyc]));
      check("busy", 32'(busy), 32'(exp_src[cyc] >= 0 || mcount > 0));
      check("cmdReady", 32'(cmdReady), 32'(mcount < DEPTH));
    end
  end

  task automatic send(input int s, input int d, input int h);
    int n = 0;
    @(negedge clock);
    cmdValid = 1'b1;
    cmdSrc = 5'(s);
    cmdDst = 5'(d);
    cmdHold = 2'(h);
    while (!cmdReady && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("send_accept", 32'(n < 100), 32'd1);
    @(posedge clock);
    #1 cmdValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (busy && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("drain", 32'(n < 300), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_strobes", 32'(dut_vec), 32'd0);
    check("rst_ready", 32'(cmdReady), 32'd1);
    #1 clear = 1'b1;
    @(negedge clock);
    check("init_busy", 32'(busy), 32'd0);
    check("init_dst", 32'(dstSelect), 32'd0);
    check("init_err", 32'(errInvalid), 32'd0);
    // single hold=0 transfer R5 -> 3
    send(5, 3, 0);
    @(negedge clock);
    @(negedge clock);
    check("t1_r5", 32'(RoutSignals), 32'h20);
    check("t1_dst", 32'(dstSelect), 32'd3);
    check("t1_load", 32'(dstLoad), 32'd1);
    @(negedge clock);
    check("t1_busy", 32'(busy), 32'd0);
    // PC -> MDR held three cycles
    send(21, 22, 2);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("t2_pc", 32'(PCout), 32'd1);
      check("t2_load", 32'(dstLoad), 32'(i == 2));
      check("t2_dst", 32'(dstSelect), 32'd22);
    end
    @(negedge clock);
    check("t2_pc_off", 32'(PCout), 32'd0);
    // back-to-back hold=0 stream
    for (int i = 0; i < 4; i++) send(i, 4 + i, 0);
    @(negedge clock);
    check("t3_r2", 32'(RoutSignals), 32'h4);
    @(negedge clock);
    check("t3_r3", 32'(RoutSignals), 32'h8);
    wait_idle();
    // fill behind a long transfer, refuse a fifth, then two wrapping refills
    send(8, 1, 3);
    for (int i = 0; i < 4; i++) send(9 + i, i, 0);
    @(negedge clock);
    check("t4_full", 32'(cmdReady), 32'd0);
    cmdValid = 1'b1;
    cmdSrc = 5'd14;
    cmdDst = 5'd14;
    cmdHold = 2'd0;
    @(posedge clock);
    #1 cmdValid = 1'b0;
    for (int r = 0; r < 2; r++) begin
      send(13, 0, 3);
      for (int i = 0; i < 4; i++) send(r * 4 + i, 20 + i, 1);
    end
    wait_idle();
    // invalid source discarded, then HI
    send(27, 1, 0);
    send(16, 2, 0);
    @(negedge clock);
    check("t5_err", 32'(errInvalid), 32'd1);
    check("t5_nostrobe", 32'(dut_vec), 32'd0);
    @(negedge clock);
    check("t5_hi", 32'(HIout), 32'd1);
    check("t5_load", 32'(dstLoad), 32'd1);
    check("t5_err_off", 32'(errInvalid), 32'd0);
    wait_idle();
    // reset in the second cycle of a hold=3 transfer with two queued
    send(4, 9, 3);
    send(6, 1, 0);
    send(7, 2, 0);
    check("t6_r4", 32'(RoutSignals), 32'h10);
    #1 clear = 1'b0;
    #1;
    check("t6_async_strobes", 32'(dut_vec), 32'd0);
    check("t6_async_load", 32'(dstLoad), 32'd0);
    check("t6_async_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1 clear = 1'b1;
    repeat (4) begin
      @(negedge clock);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_ready", 32'(cmdReady), 32'd1);
      check("t6_strobes", 32'(dut_vec), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
